// File: rtl/mfp_fifo_rd_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream drainer.
// The FIFO read latency and buffer depth are fixed by the mfp_fifo_dc read port.
package mfp_fifo_rd_stream_pkg;

    localparam int FIFO_RD_LATENCY = 1;
    localparam int BUF_DEPTH       = 2;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH   = 16;

    typedef logic [1:0] level_t;

    // Encoding is {push, pop} so the buffer can cast its strobes directly.
    typedef enum logic [1:0] {
        BUF_IDLE = 2'b00,
        BUF_POP  = 2'b01,
        BUF_PUSH = 2'b10,
        BUF_BOTH = 2'b11
    } buf_op_e;

    // A new pop may be issued only if the word it returns is guaranteed a slot.
    function automatic logic credit_ok(input level_t level, input logic inflight, input logic pop);
        logic [2:0] committed;
        committed = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
        return committed < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/mfp_fifo_rd_stream_if.sv
// Valid/ready word stream between the FIFO drainer and its consumer.
interface mfp_fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mfp_fifo_rd_stream_skid_buf2.sv
// Two-entry ordered buffer absorbing the FIFO read latency; head is always entry 0.
module mfp_fifo_rd_stream_skid_buf2
    import mfp_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output level_t                o_level,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;
    level_t                r_level;
    buf_op_e               w_op;

    assign w_op    = buf_op_e'({i_push, i_pop});
    assign o_level = r_level;
    assign o_head  = r_buf0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= '0;
            r_buf0  <= '0;
            r_buf1  <= '0;
        end else if (i_clear) begin
            // Clear drops the word landing this cycle as well as the stored ones.
            r_level <= '0;
        end else begin
            unique case (w_op)
                BUF_PUSH: begin
                    if (r_level == 2'd0) begin
                        r_buf0 <= i_push_data;
                    end else begin
                        r_buf1 <= i_push_data;
                    end
                    r_level <= r_level + 2'd1;
                end
                BUF_POP: begin
                    r_buf0  <= r_buf1;
                    r_level <= r_level - 2'd1;
                end
                BUF_BOTH: begin
                    // Tail lands behind the shifted head, so level is unchanged.
                    if (r_level == 2'd1) begin
                        r_buf0 <= i_push_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= i_push_data;
                    end
                end
                default: begin
                    r_level <= r_level;
                end
            endcase
        end
    end

endmodule

// File: rtl/mfp_fifo_rd_stream.sv
// Read-side drainer for mfp_fifo_dc: issues credited pops and presents words as a
// valid/ready stream at up to one word per clock, counting accepted transfers.
module mfp_fifo_rd_stream
    import mfp_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    output logic                      o_fifo_ren,
    input  logic [DATA_WIDTH-1:0]     i_fifo_rdata,
    input  logic                      i_fifo_rempty,
    input  logic                      i_flush,
    mfp_fifo_rd_stream_if.master      o_strm,
    output logic [1:0]                o_level,
    output logic [CNT_WIDTH-1:0]      o_count
);

    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_count;
    level_t                w_level;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_pop;

    assign w_pop        = o_strm.valid && o_strm.ready;
    assign o_strm.valid = (w_level != 2'd0);
    assign o_strm.data  = w_head;
    assign o_level      = w_level;
    assign o_count      = r_count;

    // Ready feeds the credit check combinationally so a full buffer can refill every clock.
    assign o_fifo_ren = !i_rst && !i_flush && !i_fifo_rempty &&
                        credit_ok(w_level, r_inflight, w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            r_inflight <= o_fifo_ren;
            if (w_pop) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    mfp_fifo_rd_stream_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_flush),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_rdata),
        .i_pop       (w_pop),
        .o_level     (w_level),
        .o_head      (w_head)
    );

    a_no_ren_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_fifo_ren && i_fifo_rempty));

    a_credit: assert property (@(posedge i_clk) disable iff (i_rst)
        ({1'b0, w_level} + {2'b00, r_inflight}) <= 3'(BUF_DEPTH));

endmodule
